// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Result, borrow-out and overflow are presented with a single-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             amsb, bmsb;
  logic             accept, last;
  logic             d, brn;

  assign accept = start && (state != SHIFT);
  assign last   = (cnt == CW'(WIDTH - 1));

  // One full-subtractor slice on the current LSBs.
  assign d   = sa[0] ^ sb[0] ^ br;
  assign brn = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = SHIFT;
      SHIFT:   if (last) nxt = DONE;
      DONE:    nxt = start ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      amsb <= 1'b0;
      bmsb <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      br   <= bin;
      cnt  <= '0;
      amsb <= a[WIDTH-1];
      bmsb <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      br   <= brn;
      cnt  <= cnt + 1'b1;
      diff <= {d, diff[WIDTH-1:1]};
      // Final slice: d is the result MSB, brn the borrow-out.
      if (last) begin
        bout <= brn;
        ovf  <= (amsb ^ bmsb) & (amsb ^ d);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases, exhaustive back-to-back,
// start-while-busy, reset abort, and random operands against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff),
    .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) ndone++;

  // Returns {ovf, bout, diff} from plain integer arithmetic.
  function automatic logic [W+1:0] model(
    input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    logic [W:0] r;
    int sa, sb, sr;
    logic o;
    r  = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
    sa = ta[W-1] ? int'(ta) - (1 << W) : int'(ta);
    sb = tb[W-1] ? int'(tb) - (1 << W) : int'(tb);
    sr = sa - sb - int'(tbin);
    o  = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    return {o, r[W], r[W-1:0]};
  endfunction

  task automatic scramble;
    a   = W'($urandom);
    b   = W'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input string nm);
    logic [W+1:0] exp;
    int cyc;
    exp = model(ta, tb, tbin);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got %b want 1", nm, busy);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc < 3 * W) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != W + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d done=%b want %0d", nm, cyc, done, W + 1);
    end
    checks++;
    if ({ovf, bout, diff} !== exp) begin
      errors++;
      $display("FAIL %s result: got ovf=%b bout=%b diff=%h want ovf=%b bout=%b diff=%h",
               nm, ovf, bout, diff, exp[W+1], exp[W], exp[W-1:0]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {ovf, bout, diff} !== exp) begin
      errors++;
      $display("FAIL %s hold: got done=%b busy=%b diff=%h want 0 0 %h",
               nm, done, busy, diff, exp[W-1:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b diff=%h bout=%b ovf=%b want 0",
               busy, done, diff, bout, ovf);
    end
  endtask

  task automatic test_directed;
    run_op(4'd5, 4'd3, 1'b0, "sub_5_3");
    run_op(4'd3, 4'd5, 1'b0, "sub_3_5");
    run_op(4'd0, 4'd0, 1'b1, "sub_0_0_bin");
    run_op(4'd8, 4'd1, 1'b0, "ovf_neg");
    run_op(4'd7, 4'hF, 1'b0, "ovf_pos");
  endtask

  task automatic test_back_to_back;
    int total, base, cyc;
    logic [2*W:0] v;
    logic [W+1:0] exp;
    total = 1 << (2 * W + 1);
    base  = ndone;
    @(negedge clk);
    v = '0;
    {a, b, bin} = v;
    start = 1'b1;
    for (int n = 0; n < total; n++) begin
      v   = (2*W+1)'(n);
      exp = model(v[2*W:W+1], v[W:1], v[0]);
      @(negedge clk);
      start = 1'b0;
      scramble();
      cyc = 1;
      while (done !== 1'b1 && cyc < 3 * W) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (done !== 1'b1 || cyc != W + 1 || {ovf, bout, diff} !== exp) begin
        errors++;
        $display("FAIL b2b op %0d: got done=%b cyc=%0d ovf=%b bout=%b diff=%h want %b",
                 n, done, cyc, ovf, bout, diff, exp);
      end
      if (n < total - 1) begin
        v = (2*W+1)'(n + 1);
        {a, b, bin} = v;
        start = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if (ndone - base != total) begin
      errors++;
      $display("FAIL b2b done count: got %0d want %0d", ndone - base, total);
    end
  endtask

  task automatic test_start_while_busy;
    logic [W+1:0] exp;
    int base;
    exp = model(4'd9, 4'd2, 1'b1);
    @(negedge clk);
    a = 4'd9; b = 4'd2; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd14; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = ndone;
    repeat (W + 4) @(negedge clk);
    checks++;
    if (ndone - base != 1) begin
      errors++;
      $display("FAIL busy_start dones: got %0d want 1", ndone - base);
    end
    checks++;
    if ({ovf, bout, diff} !== exp) begin
      errors++;
      $display("FAIL busy_start result: got %b%b%h want %b", ovf, bout, diff, exp);
    end
  endtask

  task automatic test_rst_abort;
    int base;
    @(negedge clk);
    a = 4'd12; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    base = ndone;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      errors++;
      $display("FAIL abort: got busy=%b done=%b diff=%h bout=%b ovf=%b want 0",
               busy, done, diff, bout, ovf);
    end
    repeat (W + 3) @(negedge clk);
    checks++;
    if (ndone != base) begin
      errors++;
      $display("FAIL abort dones: got %0d want 0", ndone - base);
    end
    run_op(4'd12, 4'd3, 1'b0, "after_abort");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_while_busy();
    test_rst_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
